peripheral_dpram: RTL and testbench
===================================

PERIPHERAL_DPRAM -- requirements
Module: peripheral_dpram

Interface
REQ-001 Parameter DATA_W, default 16, data width of bus and memory word.
REQ-002 Parameter ADDR_W, default 8, memory address width; depth = 2**ADDR_W words.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cs  input  1  peripheral select.
REQ-006 rd  input  1  bus read strobe, qualified by cs.
REQ-007 wr  input  1  bus write strobe, qualified by cs.
REQ-008 addr  input  4  register offset.
REQ-009 dat_in  input  DATA_W  bus write data.
REQ-010 dat_out  output  DATA_W  registered bus read data.
REQ-011 dp_rd_addr  input  ADDR_W  second-port (consumer) read address.
REQ-012 dp_rd_data  output  DATA_W  second-port read data, 1-cycle latency.
REQ-013 done  output  1  one-cycle pulse when a memory command completes.

Function
REQ-014 Register map: 0x0 WDATA (W), 0x2 RDATA (R), 0x4 PTR (R/W, low ADDR_W bits), 0x6 STATUS (R), 0x8 CMD (W); other offsets: writes ignored, reads return 0.
REQ-015 STATUS bits: [0] busy, [1] rd_valid, [2] overrun (sticky); upper bits 0.
REQ-016 Bus write occurs on a rising edge with cs=1, wr=1; if wr and rd are both high, wr wins and the read is ignored.
REQ-017 Bus read: on a rising edge with cs=1, rd=1, wr=0, dat_out loads the addressed register; otherwise dat_out holds its value.
REQ-018 CMD write with dat_in[0]=0 starts a memory write: mem[PTR] <= WDATA.
REQ-019 CMD write with dat_in[0]=1 starts a memory read: RDATA <= mem[PTR]; rd_valid set on completion.
REQ-020 FSM states IDLE, WR_MEM, RD_MEM, RD_CAP; IDLE->WR_MEM or RD_MEM on CMD accept; WR_MEM->IDLE; RD_MEM->RD_CAP->IDLE.
REQ-021 Latency from the CMD edge: write commits 1 cycle later; RDATA valid 2 cycles later; done pulses in the cycle following commit/capture.
REQ-022 busy = 1 in every state other than IDLE.
REQ-023 A CMD write while busy is dropped, sets overrun, and leaves the FSM, memory and PTR unchanged.
REQ-024 Writes to WDATA or PTR while busy are accepted; the in-flight command uses values latched at CMD accept.
REQ-025 A bus read of RDATA clears rd_valid; a bus read of STATUS clears overrun after returning it.
REQ-026 Second port is independent: dp_rd_data <= mem[dp_rd_addr] every cycle; on a same-address collision with a memory write it returns the old data.

Reset
REQ-027 On rst: FSM IDLE; dat_out, dp_rd_data, WDATA, RDATA, PTR and STATUS all 0; done 0.
REQ-028 Reset mid-command aborts the command; memory contents are not cleared, and a write not yet committed is discarded.

Configuration
REQ-029 Macro DPRAM_AUTOINC_EN: when defined, PTR increments by 1 on each completed memory command, wrapping from 2**ADDR_W-1 to 0.
REQ-030 Without DPRAM_AUTOINC_EN, PTR changes only on bus writes to 0x4.

Structure
REQ-031 Shared package holds register offsets, STATUS bit indices, CMD codes and the FSM state enumeration.
REQ-032 Memory array is a sub-module dpram_core (one write/read port plus one read-only port, synchronous, read-old-data on collision).

Verification
REQ-033 Write WDATA=0x000B, PTR=0x80, CMD=0; then PTR=0x80, CMD=1 -> done pulses, RDATA read returns 0x000B, rd_valid cleared after read.
REQ-034 Write 0x00FF to 0x55, then drive dp_rd_addr=0x55 -> dp_rd_data=0x00FF one cycle later; memory write to 0x55 with dp_rd_addr=0x55 in the same cycle -> old value returned.
REQ-035 Issue CMD=1, then CMD=0 on the next cycle -> second command dropped, STATUS=0x5 (busy, overrun), memory unchanged; STATUS read then clears overrun.
REQ-036 With DPRAM_AUTOINC_EN, PTR=0xFF, two write commands -> data lands at 0xFF and 0x00, PTR reads 0x01; without the macro both land at 0xFF.
REQ-037 Assert rst one cycle after a write command -> target word keeps its old value, all outputs 0, busy 0.

Source files
------------

// File: rtl/peripheral_dpram_pkg.sv
// peripheral_dpram_pkg
//   Shared definitions for the peripheral_dpram block: register offsets,
//   STATUS bit positions, CMD codes and the command FSM state encoding.
package peripheral_dpram_pkg;

    // Register offsets (4-bit bus offset)
    localparam logic [3:0] REG_WDATA  = 4'h0;
    localparam logic [3:0] REG_RDATA  = 4'h2;
    localparam logic [3:0] REG_PTR    = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h6;
    localparam logic [3:0] REG_CMD    = 4'h8;

    // STATUS bit indices
    localparam int ST_BUSY     = 0;
    localparam int ST_RD_VALID = 1;
    localparam int ST_OVERRUN  = 2;

    // CMD codes (dat_in[0] of a CMD write)
    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WR_MEM = 2'd1,
        S_RD_MEM = 2'd2,
        S_RD_CAP = 2'd3
    } state_t;

endpackage

// File: rtl/peripheral_dpram_core.sv
// dpram_core
//   Synchronous dual-port memory: port A read/write, port B read-only.
//   Both reads are registered; a read on the same address as a port A write
//   returns the old word.  The array itself is never reset; only the read
//   data registers are.
//   Ports: clk, rst (async, active-high), we_a/addr_a/din_a/q_a (port A),
//          addr_b/q_b (port B).
module dpram_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] q_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] q_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
    end

    // Non-blocking reads sample the array before this edge's write lands,
    // which gives read-old-data on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            q_a <= mem[addr_a];
            q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/peripheral_dpram.sv
// peripheral_dpram
//   Bus-mapped register front end for a dual-port RAM.  The bus side stages
//   WDATA/PTR and issues memory commands through CMD; a second, independent
//   read port serves a consumer.
//   Ports: clk, rst (async, active-high), cs/rd/wr/addr/dat_in/dat_out (bus),
//          dp_rd_addr/dp_rd_data (consumer read port, 1-cycle latency),
//          done (one-cycle pulse after a memory command completes).
//   Build option: DPRAM_AUTOINC_EN -- PTR advances by one (wrapping) on each
//   completed memory command.
module peripheral_dpram
    import peripheral_dpram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic [3:0]        addr,
    input  logic [DATA_W-1:0] dat_in,
    output logic [DATA_W-1:0] dat_out,
    input  logic [ADDR_W-1:0] dp_rd_addr,
    output logic [DATA_W-1:0] dp_rd_data,
    output logic              done
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] wdata, rdata, cmd_wdata, rd_mux, q_a;
    logic [ADDR_W-1:0] ptr, cmd_ptr;
    logic              rd_valid, overrun, busy;
    logic [2:0]        status;
    logic              bus_wr, bus_rd, cmd_wr, cmd_acc, cmd_drop, cmd_done;

    // Write wins over a simultaneous read.
    assign bus_wr   = cs & wr;
    assign bus_rd   = cs & rd & ~wr;
    assign cmd_wr   = bus_wr && (addr == REG_CMD);
    assign busy     = (state != S_IDLE);
    assign cmd_acc  = cmd_wr && !busy;
    assign cmd_drop = cmd_wr && busy;
    assign cmd_done = (state == S_WR_MEM) || (state == S_RD_CAP);

    always_comb begin
        status              = '0;
        status[ST_BUSY]     = busy;
        status[ST_RD_VALID] = rd_valid;
        status[ST_OVERRUN]  = overrun;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_RDATA:  rd_mux = rdata;
            REG_PTR:    rd_mux = DATA_W'(ptr);
            REG_STATUS: rd_mux = DATA_W'(status);
            default:    rd_mux = '0;
        endcase
    end

    // Command FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_acc)
                    state_nxt = (dat_in[0] == CMD_READ) ? S_RD_MEM : S_WR_MEM;
            end
            S_WR_MEM: state_nxt = S_IDLE;
            S_RD_MEM: state_nxt = S_RD_CAP;
            S_RD_CAP: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdata     <= '0;
            rdata     <= '0;
            ptr       <= '0;
            cmd_ptr   <= '0;
            cmd_wdata <= '0;
            rd_valid  <= 1'b0;
            overrun   <= 1'b0;
            done      <= 1'b0;
            dat_out   <= '0;
        end else begin
            done <= cmd_done;

            if (bus_wr && addr == REG_WDATA) wdata <= dat_in;

            // A bus write to PTR takes priority over auto-increment.
            if (bus_wr && addr == REG_PTR) ptr <= dat_in[ADDR_W-1:0];
`ifdef DPRAM_AUTOINC_EN
            else if (cmd_done)             ptr <= ptr + ADDR_W'(1);
`endif

            // Snapshot operands so later WDATA/PTR writes can't disturb
            // the command in flight.
            if (cmd_acc) begin
                cmd_ptr   <= ptr;
                cmd_wdata <= wdata;
            end

            if (state == S_RD_CAP) rdata <= q_a;

            if (state == S_RD_CAP)                  rd_valid <= 1'b1;
            else if (bus_rd && addr == REG_RDATA)   rd_valid <= 1'b0;

            if (cmd_drop)                           overrun <= 1'b1;
            else if (bus_rd && addr == REG_STATUS)  overrun <= 1'b0;

            if (bus_rd) dat_out <= rd_mux;
        end
    end

    // Port A is written only in WR_MEM; reset forces IDLE, so an
    // uncommitted write is discarded.
    dpram_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
        .clk    (clk),
        .rst    (rst),
        .we_a   (state == S_WR_MEM),
        .addr_a (cmd_ptr),
        .din_a  (cmd_wdata),
        .q_a    (q_a),
        .addr_b (dp_rd_addr),
        .q_b    (dp_rd_data)
    );

endmodule

// File: tb/tb_peripheral_dpram.sv
// tb_peripheral_dpram
//   Directed testbench for peripheral_dpram (DATA_W=16, ADDR_W=8).
//   Honours DPRAM_AUTOINC_EN for the pointer expectations.
module tb_peripheral_dpram;

    logic        clk = 1'b0;
    logic        rst, cs, rd, wr;
    logic [3:0]  addr;
    logic [15:0] dat_in, dat_out;
    logic [7:0]  dp_rd_addr;
    logic [15:0] dp_rd_data;
    logic        done;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] A_WDATA = 4'h0, A_RDATA = 4'h2, A_PTR = 4'h4,
                           A_STATUS = 4'h6, A_CMD = 4'h8;

    peripheral_dpram #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .dat_in     (dat_in),
        .dat_out    (dat_out),
        .dp_rd_addr (dp_rd_addr),
        .dp_rd_data (dp_rd_data),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Every bus task returns 1 time unit after the edge that performed it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; dat_in = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [15:0] d);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        tick();
        cs = 1'b0; rd = 1'b0;
        d = dat_out;
    endtask

    // Full memory write, waits for completion.
    task automatic mem_write(input logic [7:0] p, input logic [15:0] d);
        bus_wr(A_WDATA, d);
        bus_wr(A_PTR, {8'h00, p});
        bus_wr(A_CMD, 16'h0000);
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0;
        dat_in = 16'h0; dp_rd_addr = 8'h00;
        tick(); tick();
        checks++; if (dat_out !== 16'h0)    begin errors++; $display("FAIL reset_dat_out got=%h exp=0000", dat_out); end
        checks++; if (dp_rd_data !== 16'h0) begin errors++; $display("FAIL reset_dp_rd_data got=%h exp=0000", dp_rd_data); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        tick();
        bus_rd(A_STATUS, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL reset_status got=%h exp=0000", v); end
        bus_rd(A_PTR, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL reset_ptr got=%h exp=0000", v); end
        bus_rd(A_RDATA, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", v); end
    endtask

    task automatic test_write_read();
        logic [15:0] v;
        bus_wr(A_WDATA, 16'h000B);
        bus_wr(A_PTR, 16'h0080);
        bus_wr(A_CMD, 16'h0000);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wr_done_pulse got=%b exp=1", done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_done_end got=%b exp=0", done); end
        bus_wr(A_PTR, 16'h0080);
        bus_wr(A_CMD, 16'h0001);
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rd_done_early got=%b exp=0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rd_done_pulse got=%b exp=1", done); end
        bus_rd(A_STATUS, v);
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL rd_valid_set got=%h exp=0002", v); end
        bus_rd(A_RDATA, v);
        checks++; if (v !== 16'h000B) begin errors++; $display("FAIL rdata got=%h exp=000b", v); end
        bus_rd(A_STATUS, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rd_valid_clr got=%h exp=0000", v); end
        bus_rd(4'hA, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL unmapped_rd got=%h exp=0000", v); end
    endtask

    task automatic test_dp_port();
        mem_write(8'h55, 16'h00FF);
        dp_rd_addr = 8'h55;
        tick();
        checks++; if (dp_rd_data !== 16'h00FF) begin errors++; $display("FAIL dp_read got=%h exp=00ff", dp_rd_data); end
        bus_wr(A_WDATA, 16'h1234);
        bus_wr(A_PTR, 16'h0055);
        bus_wr(A_CMD, 16'h0000);
        tick(); // commit edge: port B sees the old word
        checks++; if (dp_rd_data !== 16'h00FF) begin errors++; $display("FAIL dp_collision_old got=%h exp=00ff", dp_rd_data); end
        tick();
        checks++; if (dp_rd_data !== 16'h1234) begin errors++; $display("FAIL dp_after_write got=%h exp=1234", dp_rd_data); end
    endtask

    task automatic test_overrun();
        logic [15:0] v;
        bus_wr(A_PTR, 16'h0055);
        bus_wr(A_WDATA, 16'hBEEF);
        bus_wr(A_CMD, 16'h0001);
        bus_wr(A_CMD, 16'h0000);   // dropped: FSM in RD_MEM
        bus_rd(A_STATUS, v);
        checks++; if (v !== 16'h0005) begin errors++; $display("FAIL overrun_status got=%h exp=0005", v); end
        bus_rd(A_STATUS, v);
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL overrun_cleared got=%h exp=0002", v); end
        bus_rd(A_RDATA, v);
        checks++; if (v !== 16'h1234) begin errors++; $display("FAIL overrun_rdata got=%h exp=1234", v); end
        dp_rd_addr = 8'h55;
        tick(); tick();
        checks++; if (dp_rd_data !== 16'h1234) begin errors++; $display("FAIL overrun_mem got=%h exp=1234", dp_rd_data); end
        bus_rd(A_PTR, v);
`ifdef DPRAM_AUTOINC_EN
        checks++; if (v !== 16'h0056) begin errors++; $display("FAIL overrun_ptr got=%h exp=0056", v); end
`else
        checks++; if (v !== 16'h0055) begin errors++; $display("FAIL overrun_ptr got=%h exp=0055", v); end
`endif
    endtask

    task automatic test_autoinc();
        logic [15:0] v;
        mem_write(8'h00, 16'h7777);
        bus_wr(A_PTR, 16'h00FF);
        bus_wr(A_WDATA, 16'h0A0A);
        bus_wr(A_CMD, 16'h0000);
        tick(); tick();
        bus_wr(A_WDATA, 16'h0B0B);
        bus_wr(A_CMD, 16'h0000);
        tick(); tick();
        dp_rd_addr = 8'hFF;
        tick();
`ifdef DPRAM_AUTOINC_EN
        checks++; if (dp_rd_data !== 16'h0A0A) begin errors++; $display("FAIL autoinc_ff got=%h exp=0a0a", dp_rd_data); end
        dp_rd_addr = 8'h00;
        tick();
        checks++; if (dp_rd_data !== 16'h0B0B) begin errors++; $display("FAIL autoinc_00 got=%h exp=0b0b", dp_rd_data); end
        bus_rd(A_PTR, v);
        checks++; if (v !== 16'h0001) begin errors++; $display("FAIL autoinc_ptr got=%h exp=0001", v); end
`else
        checks++; if (dp_rd_data !== 16'h0B0B) begin errors++; $display("FAIL noinc_ff got=%h exp=0b0b", dp_rd_data); end
        dp_rd_addr = 8'h00;
        tick();
        checks++; if (dp_rd_data !== 16'h7777) begin errors++; $display("FAIL noinc_00 got=%h exp=7777", dp_rd_data); end
        bus_rd(A_PTR, v);
        checks++; if (v !== 16'h00FF) begin errors++; $display("FAIL noinc_ptr got=%h exp=00ff", v); end
`endif
    endtask

    task automatic test_reset_abort();
        logic [15:0] v;
        bus_rd(A_STATUS, v);        // leave dat_out non-zero-capable path exercised
        bus_wr(A_PTR, 16'h0080);
        bus_wr(A_WDATA, 16'hDEAD);
        bus_wr(A_CMD, 16'h0000);
        rst = 1'b1;                 // before the commit edge
        #1;
        checks++; if (dat_out !== 16'h0)    begin errors++; $display("FAIL abort_dat_out got=%h exp=0000", dat_out); end
        checks++; if (dp_rd_data !== 16'h0) begin errors++; $display("FAIL abort_dp_rd_data got=%h exp=0000", dp_rd_data); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        tick();
        rst = 1'b0;
        dp_rd_addr = 8'h80;
        tick();
        checks++; if (dp_rd_data !== 16'h000B) begin errors++; $display("FAIL abort_mem got=%h exp=000b", dp_rd_data); end
        bus_rd(A_STATUS, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL abort_status got=%h exp=0000", v); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_dp_port();
        test_overrun();
        test_autoinc();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
